serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port for a-b via two's complement.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction is a + ~b + 1, so only the loaded addend and carry differ.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  always_comb begin
    sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_out = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = carry_out;
        cnt_d   = cnt_q + CW'(1);
        // The final bit goes straight to the outputs so sum is valid with done.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {sum_bit, res_q[WIDTH-1:1]};
          cout_d  = carry_out;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
